branch_target_predictor: RTL and testbench
==========================================

// Module: branch_target_predictor
// PURPOSE
//  - Fetch-redirect controller for the IF stage: a direct-mapped BTB with 2-bit saturating counters.
//  - Looks up the current fetch PC combinationally and supplies the predicted next PC and a taken flag to the PC mux.
//  - Trained from the resolve stage on every branch or jump retirement.
//  - Flags mispredictions so hazard logic can squash IF/ID and redirect fetch.
// PARAMETERS
//  IDX_W   6   index bits; ENTRIES = 2**IDX_W; index = pc[IDX_W+1:2]
//  TAG_W   8   tag bits; tag = pc[IDX_W+TAG_W+1:IDX_W+2]
// PORTS
//  clk             in   1   clock; all state updates on posedge
//  clear_n         in   1   asynchronous, active-low reset
//  flush           in   1   sync invalidate of all entries
//  fetch_pc        in   32  current fetch PC
//  pred_hit        out  1   valid entry with matching tag
//  pred_taken      out  1   pred_hit & ctr[1]
//  pred_target     out  32  stored target if pred_taken, else fetch_pc+4
//  upd_valid       in   1   resolve stage retires a branch/jump this cycle
//  upd_pc          in   32  PC of resolved instruction
//  upd_taken       in   1   actual direction
//  upd_target      in   32  actual taken target
//  upd_pred_taken  in   1   prediction that was used for this instruction
//  upd_pred_target in   32  target that was used for this instruction
//  mispredict      out  1   misprediction flag (see BEHAVIOUR)
// BEHAVIOUR
//  - State per entry: valid, tag[TAG_W], target[32], ctr[2].
//    Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST.
//  - Reset (clear_n=0, async): all valid=0, all ctr=01, all target=0.
//    Outputs then: pred_hit=0, pred_taken=0, pred_target=fetch_pc+4, mispredict=0.
//  - Lookup is combinational with zero latency.
//    Reads the pre-edge state; an update to the same index becomes visible the cycle after its edge.
//  - mispredict (combinational) =
//    upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_pred_taken & upd_target != upd_pred_target)).
//  - Update (posedge, upd_valid=1, flush=0) on idx/tag of upd_pc:
//    - Hit, taken: ctr <= sat_inc(ctr); target <= upd_target.
//    - Hit, not taken: ctr <= sat_dec(ctr); target unchanged.
//    - Miss, taken: allocate, overwriting any existing entry.
//      valid <= 1, tag, target <= upd_target, ctr <= 10.
//    - Miss, not taken: no change.
//  - Counter saturation: 11 + inc stays 11; 00 + dec stays 00. No wrap.
//  - flush=1: all valid <= 0 at the edge; ctr and target are untouched.
//    A simultaneous update is discarded (flush wins).
//  - PC bits [1:0] are ignored for index and tag. pred_target arithmetic is mod 2**32.
//  - Reset asserted mid-operation clears state immediately.
//    Outputs follow within the same cycle through the combinational lookup.
// CONFIGURATION
//  - BTP_STATS_EN defined adds outputs:
//    - stat_updates[31:0]: count of accepted updates.
//    - stat_mispred[31:0]: count of cycles with mispredict=1 and flush=0.
//    - Both are 0 at reset, wrap modulo 2**32, and are not cleared by flush.
//  - BTP_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1. Reset, fetch_pc=0x40 -> pred_hit=0, pred_taken=0, pred_target=0x44.
//  2. Update pc=0x40 taken target=0x100, pred_taken=0 -> mispredict=1 that cycle.
//     Next cycle fetch_pc=0x40 gives hit=1, taken=1, target=0x100.
//  3. Entry from (2), two not-taken updates -> ctr 10->01->00.
//     Lookup gives taken=0, target=0x44. Third not-taken keeps ctr 00.
//  4. Alias: taken update at 0x40 then taken update at 0x40+(4<<IDX_W) target=0x200.
//     Lookup 0x40 misses; lookup of the alias address hits with 0x200.
//  5. flush=1 and upd_valid=1 in the same cycle -> all lookups miss next cycle.
//     No allocation occurs; stat_updates is unchanged (BTP_STATS_EN).
//  6. Drop clear_n between clock edges after training -> pred_hit falls to 0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Optional statistics counters are enabled by defining BTP_STATS_EN.
module branch_target_predictor #(
  parameter int IDX_W = 6,
  parameter int TAG_W = 8
) (
  input  logic        clk,
  input  logic        clear_n,
  input  logic        flush,
  input  logic [31:0] fetch_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict
`ifdef BTP_STATS_EN
  ,
  output logic [31:0] stat_updates,
  output logic [31:0] stat_mispred
`endif
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int PC_HI   = IDX_W + TAG_W + 1;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [1:0]       upd_ctr;
  logic [1:0]       ctr_inc;
  logic [1:0]       ctr_dec;
  logic             unused_bits;

  assign fetch_idx = fetch_pc[IDX_W+1:2];
  assign fetch_tag = fetch_pc[PC_HI:IDX_W+2];
  assign upd_idx   = upd_pc[IDX_W+1:2];
  assign upd_tag   = upd_pc[PC_HI:IDX_W+2];

  // PC bits outside the index/tag fields play no part in lookup or training.
  assign unused_bits = ^{fetch_pc[31:PC_HI+1], fetch_pc[1:0],
                         upd_pc[31:PC_HI+1], upd_pc[1:0]};

  // Zero-latency lookup against the pre-edge table contents.
  always_comb begin
    pred_hit    = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    pred_taken  = pred_hit && ctr_q[fetch_idx][1];
    pred_target = pred_taken ? target_q[fetch_idx] : fetch_pc + 32'd4;
  end

  assign mispredict = upd_valid &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));

  always_comb begin
    upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_ctr = ctr_q[upd_idx];
    ctr_inc = (upd_ctr == CTR_ST)  ? CTR_ST  : upd_ctr + 2'd1;
    ctr_dec = (upd_ctr == CTR_SNT) ? CTR_SNT : upd_ctr - 2'd1;
  end

  // Flush only drops valid bits and overrides any same-cycle training.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          ctr_q[upd_idx]    <= ctr_inc;
          target_q[upd_idx] <= upd_target;
        end else begin
          ctr_q[upd_idx] <= ctr_dec;
        end
      end else if (upd_taken) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
        ctr_q[upd_idx]    <= CTR_WT;
      end
    end
  end

`ifdef BTP_STATS_EN
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      stat_updates <= '0;
      stat_mispred <= '0;
    end else if (!flush) begin
      if (upd_valid) begin
        stat_updates <= stat_updates + 32'd1;
      end
      if (mispredict) begin
        stat_mispred <= stat_mispred + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// Randomized self-checking bench for branch_target_predictor against a behavioural table model.
// Stats ports are connected and checked only when BTP_STATS_EN is defined.
module tb_branch_target_predictor;

  logic        clk;
  logic        clear_n;
  logic        flush;
  logic [31:0] fetch_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
`ifdef BTP_STATS_EN
  logic [31:0] stat_updates;
  logic [31:0] stat_mispred;
`endif

  int checks = 0;
  int failures = 0;

  // Behavioural model: one record per table slot, counter held as 0..3.
  bit          m_valid  [64];
  int unsigned m_tag    [64];
  logic [31:0] m_target [64];
  int          m_ctr    [64];
  logic [31:0] m_stat_upd;
  logic [31:0] m_stat_mis;

  branch_target_predictor dut (
    .clk             (clk),
    .clear_n         (clear_n),
    .flush           (flush),
    .fetch_pc        (fetch_pc),
    .pred_hit        (pred_hit),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict)
`ifdef BTP_STATS_EN
    ,
    .stat_updates    (stat_updates),
    .stat_mispred    (stat_mispred)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int slotOf(logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  function automatic int unsigned tagOf(logic [31:0] pc);
    return (pc / 256) % 256;
  endfunction

  function automatic bit modelHit(logic [31:0] pc);
    return m_valid[slotOf(pc)] && (m_tag[slotOf(pc)] == tagOf(pc));
  endfunction

  function automatic bit modelTaken(logic [31:0] pc);
    return modelHit(pc) && (m_ctr[slotOf(pc)] >= 2);
  endfunction

  function automatic logic [31:0] modelTarget(logic [31:0] pc);
    return modelTaken(pc) ? m_target[slotOf(pc)] : pc + 32'd4;
  endfunction

  function automatic bit modelMispredict();
    if (!upd_valid) return 1'b0;
    if (upd_taken != upd_pred_taken) return 1'b1;
    return upd_taken && (upd_target != upd_pred_target);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i]  = 1'b0;
      m_tag[i]    = 0;
      m_target[i] = 32'd0;
      m_ctr[i]    = 1;
    end
    m_stat_upd = 32'd0;
    m_stat_mis = 32'd0;
  endtask

  // Applies the effect of one clock edge using the inputs present at that edge.
  task automatic modelEdge();
    int s;
    s = slotOf(upd_pc);
    if (modelMispredict() && !flush) m_stat_mis = m_stat_mis + 32'd1;
    if (upd_valid && !flush) m_stat_upd = m_stat_upd + 32'd1;
    if (flush) begin
      for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    end else if (upd_valid) begin
      if (modelHit(upd_pc)) begin
        if (upd_taken) begin
          m_ctr[s]    = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
          m_target[s] = upd_target;
        end else begin
          m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
        end
      end else if (upd_taken) begin
        m_valid[s]  = 1'b1;
        m_tag[s]    = tagOf(upd_pc);
        m_target[s] = upd_target;
        m_ctr[s]    = 2;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] fpc, input logic uv, input logic [31:0] upc,
                               input logic ut, input logic [31:0] utgt, input logic upt,
                               input logic [31:0] uptgt, input logic fl);
    fetch_pc        = fpc;
    upd_valid       = uv;
    upd_pc          = upc;
    upd_taken       = ut;
    upd_target      = utgt;
    upd_pred_taken  = upt;
    upd_pred_target = uptgt;
    flush           = fl;
  endtask

  task automatic checkLookup(input string where);
    checkOutput({where, ".pred_hit"},    {31'd0, pred_hit},   {31'd0, modelHit(fetch_pc)});
    checkOutput({where, ".pred_taken"},  {31'd0, pred_taken}, {31'd0, modelTaken(fetch_pc)});
    checkOutput({where, ".pred_target"}, pred_target,         modelTarget(fetch_pc));
    checkOutput({where, ".mispredict"},  {31'd0, mispredict}, {31'd0, modelMispredict()});
`ifdef BTP_STATS_EN
    checkOutput({where, ".stat_updates"}, stat_updates, m_stat_upd);
    checkOutput({where, ".stat_mispred"}, stat_mispred, m_stat_mis);
`endif
  endtask

  // Inputs are already applied at posedge+1; check mid-cycle, then clock them in.
  task automatic runCycle(input string where);
    #2;
    checkLookup(where);
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic lookupOnly(input logic [31:0] fpc, input string where);
    applyStimulus(fpc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    runCycle(where);
  endtask

  task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                       input string where);
    applyStimulus(pc, 1'b1, pc, taken, tgt, 1'b0, 32'd0, 1'b0);
    runCycle(where);
  endtask

  initial begin
    logic [31:0] pc_a;
    logic [31:0] pc_b;
    logic [31:0] tgt;
    modelReset();
    clear_n = 1'b0;
    applyStimulus(32'h40, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    #3;
    checkLookup("reset");
    checkOutput("reset.target_const", pred_target, 32'h44);
    #4 clear_n = 1'b1;
    @(posedge clk);
    #1;

    // Allocation on a mispredicted taken branch, then zero-latency lookup.
    applyStimulus(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'd0, 1'b0);
    #2;
    checkOutput("alloc.mispredict_const", {31'd0, mispredict}, 32'd1);
    checkOutput("alloc.same_cycle_hit", {31'd0, pred_hit}, 32'd0);
    runCycle("alloc");
    lookupOnly(32'h40, "alloc_lookup");
    fetch_pc = 32'h40;
    #2;
    checkOutput("alloc.target_const", pred_target, 32'h100);

    // Decrement to strongly-not-taken and saturate, then one taken step.
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) train(32'h40, 1'b0, 32'd0, "dec");
    lookupOnly(32'h40, "dec_lookup");
    train(32'h40, 1'b1, 32'h180, "inc_from_snt");
    lookupOnly(32'h40, "inc_lookup");
    for (int i = 0; i < 4; i++) train(32'h40, 1'b1, 32'h1c0, "inc_sat");
    lookupOnly(32'h40, "sat_lookup");

    // Alias in the same slot replaces the older entry.
    train(32'h140, 1'b1, 32'h200, "alias");
    lookupOnly(32'h40, "alias_old");
    lookupOnly(32'h140, "alias_new");
    fetch_pc = 32'h140;
    #2;
    checkOutput("alias.target_const", pred_target, 32'h200);
    @(posedge clk);
    #1;

    // Flush wins over a simultaneous allocation.
    applyStimulus(32'h140, 1'b1, 32'h80, 1'b1, 32'h300, 1'b1, 32'h300, 1'b1);
    runCycle("flush");
    lookupOnly(32'h80, "flush_alloc");
    lookupOnly(32'h140, "flush_old");

    // Randomized traffic over a small PC pool so hits and aliases are frequent.
    for (int n = 0; n < 600; n++) begin
      pc_a = ($urandom_range(0, 15) << 2) | ($urandom_range(0, 3) << 8) | $urandom_range(0, 3);
      pc_b = ($urandom_range(0, 15) << 2) | ($urandom_range(0, 3) << 8) | $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) pc_b = pc_b | 32'hFFFF_0000;
      tgt  = ($urandom_range(0, 1) == 0) ? $urandom() : 32'h1000 + ($urandom_range(0, 7) << 4);
      applyStimulus(pc_a, $urandom_range(0, 3) != 0, pc_b, $urandom_range(0, 1) == 1, tgt,
                    $urandom_range(0, 1) == 1,
                    ($urandom_range(0, 1) == 1) ? tgt : 32'h1000 + ($urandom_range(0, 7) << 4),
                    $urandom_range(0, 24) == 0);
      runCycle("random");
    end

    // Wrap of the fall-through target at the top of the address space.
    lookupOnly(32'hFFFF_FFFC, "wrap");

    // Train, then drop clear_n between edges and expect the hit to vanish at once.
    train(32'h40, 1'b1, 32'h500, "pre_async");
    applyStimulus(32'h40, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    #2;
    checkOutput("async.hit_before", {31'd0, pred_hit}, 32'd1);
    clear_n = 1'b0;
    modelReset();
    #1;
    checkLookup("async");
    checkOutput("async.hit_const", {31'd0, pred_hit}, 32'd0);
    #1 clear_n = 1'b1;
    @(posedge clk);
    #1;
    lookupOnly(32'h40, "post_async");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
